// File: rtl/usb_fs_out_arb_if.sv
// Bus bundle between the USB FS receiver, the OUT endpoint buffers, the
// shared transmit path and the OUT arbiter. The master modport is the
// arbiter side. The slave modport is the surrounding environment.
interface usb_fs_out_arb_if #(
    parameter int NUM_OUT_EP = 2
);
    // receiver -> arbiter
    logic                  rx_pkt_start;
    logic                  rx_pkt_end;
    logic [3:0]            rx_pid;
    logic [6:0]            rx_addr;
    logic [3:0]            rx_endp;
    logic                  rx_pkt_valid;
    logic                  rx_data_put;
    logic [7:0]            rx_data;
    // endpoint buffers <-> arbiter
    logic [NUM_OUT_EP-1:0] out_ep_data_avail;
    logic [NUM_OUT_EP-1:0] out_ep_stall;
    logic [NUM_OUT_EP-1:0] out_ep_grant;
    logic                  out_ep_setup;
    logic                  out_ep_data_put;
    logic [7:0]            out_ep_data;
    logic                  out_ep_acked;
    logic                  out_ep_rollback;
    // transmit path <-> arbiter
    logic                  tx_hs_req;
    logic [3:0]            tx_hs_pid;
    logic                  tx_hs_grant;

    modport master (
        input  rx_pkt_start, rx_pkt_end, rx_pid, rx_addr, rx_endp,
               rx_pkt_valid, rx_data_put, rx_data,
               out_ep_data_avail, out_ep_stall, tx_hs_grant,
        output out_ep_grant, out_ep_setup, out_ep_data_put, out_ep_data,
               out_ep_acked, out_ep_rollback, tx_hs_req, tx_hs_pid
    );

    modport slave (
        output rx_pkt_start, rx_pkt_end, rx_pid, rx_addr, rx_endp,
               rx_pkt_valid, rx_data_put, rx_data,
               out_ep_data_avail, out_ep_stall, tx_hs_grant,
        input  out_ep_grant, out_ep_setup, out_ep_data_put, out_ep_data,
               out_ep_acked, out_ep_rollback, tx_hs_req, tx_hs_pid
    );
endinterface

// File: rtl/usb_fs_out_arb.sv
// USB full-speed OUT/SETUP receive sequencer. Matches tokens against the
// device address, steers the following data packet to one endpoint buffer,
// tracks DATA0/DATA1 toggles per endpoint and requests the ACK/NAK/STALL
// handshake from the shared transmit path.
// All outputs are registered, so they follow the FSM state by one cycle.
module usb_fs_out_arb #(
    parameter int NUM_OUT_EP = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       dev_addr,
    usb_fs_out_arb_if.master bus
);
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int EW = (NUM_OUT_EP > 1) ? $clog2(NUM_OUT_EP) : 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_DATA      = 3'd2,
        ST_EVAL      = 3'd3,
        ST_SEND_HS   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  end_q;
    logic [EW-1:0]         ep_q, ep_d;
    logic                  is_setup_q, is_setup_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [NUM_OUT_EP-1:0] toggle_q, toggle_d;
    logic [NUM_OUT_EP-1:0] grant_q, grant_d;
    logic                  setup_q, setup_d;
    logic                  data_put_q, data_put_d;
    logic [7:0]            data_q, data_d;
    logic                  acked_q, acked_d;
    logic                  rollback_q, rollback_d;
    logic                  hs_req_q, hs_req_d;
    logic [3:0]            hs_pid_q, hs_pid_d;

    logic                  accept_s;
    logic                  granted_s;
    logic                  pid_is_data_s;
    logic [NUM_OUT_EP-1:0] ep_onehot_s;

    // A token is ours when it is a clean OUT/SETUP to our address and a served endpoint.
    assign accept_s = bus.rx_pkt_valid
                    && ((bus.rx_pid == PID_OUT) || (bus.rx_pid == PID_SETUP))
                    && (bus.rx_addr == dev_addr)
                    && ({1'b0, bus.rx_endp} < 5'(NUM_OUT_EP));

    assign pid_is_data_s = (bus.rx_pid == PID_DATA0) || (bus.rx_pid == PID_DATA1);
    assign granted_s     = |grant_q;
    assign ep_onehot_s   = NUM_OUT_EP'(1'b1) << ep_q;

    // Delay the end strobe one cycle so the packet fields are settled when looked at.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            end_q <= 1'b0;
        end else begin
            end_q <= bus.rx_pkt_end;
        end
    end

    // State, per-transfer context, toggles and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ep_q       <= {EW{1'b0}};
            is_setup_q <= 1'b0;
            timer_q    <= {TW{1'b0}};
            toggle_q   <= {NUM_OUT_EP{1'b0}};
            grant_q    <= {NUM_OUT_EP{1'b0}};
            setup_q    <= 1'b0;
            data_put_q <= 1'b0;
            data_q     <= 8'h00;
            acked_q    <= 1'b0;
            rollback_q <= 1'b0;
            hs_req_q   <= 1'b0;
            hs_pid_q   <= 4'h0;
        end else begin
            state_q    <= state_d;
            ep_q       <= ep_d;
            is_setup_q <= is_setup_d;
            timer_q    <= timer_d;
            toggle_q   <= toggle_d;
            grant_q    <= grant_d;
            setup_q    <= setup_d;
            data_put_q <= data_put_d;
            data_q     <= data_d;
            acked_q    <= acked_d;
            rollback_q <= rollback_d;
            hs_req_q   <= hs_req_d;
            hs_pid_q   <= hs_pid_d;
        end
    end

    // Next-state and next-output decode for the transfer sequencer.
    always_comb begin
        state_d    = state_q;
        ep_d       = ep_q;
        is_setup_d = is_setup_q;
        timer_d    = timer_q;
        toggle_d   = toggle_q;
        grant_d    = grant_q;
        setup_d    = setup_q;
        data_put_d = 1'b0;
        data_d     = data_q;
        acked_d    = 1'b0;
        rollback_d = 1'b0;
        hs_req_d   = hs_req_q;
        hs_pid_d   = hs_pid_q;

        case (state_q)
            ST_IDLE: begin
                grant_d  = {NUM_OUT_EP{1'b0}};
                setup_d  = 1'b0;
                hs_req_d = 1'b0;
                if (end_q && accept_s) begin
                    ep_d       = bus.rx_endp[EW-1:0];
                    is_setup_d = (bus.rx_pid == PID_SETUP);
                    timer_d    = {TW{1'b0}};
                    state_d    = ST_WAIT_DATA;
                end else begin
                    state_d    = ST_IDLE;
                end
            end

            ST_WAIT_DATA: begin
                if (bus.rx_pkt_start) begin
                    state_d = ST_DATA;
                    if (bus.out_ep_data_avail[ep_q]) begin
                        grant_d = ep_onehot_s;
                        setup_d = is_setup_q;
                    end else begin
                        grant_d = {NUM_OUT_EP{1'b0}};
                        setup_d = 1'b0;
                    end
                end else if (bus.rx_pkt_end) begin
                    // another token overtook the expected data packet
                    state_d = ST_IDLE;
                end else if (timer_q == TW'(TIMEOUT)) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            ST_DATA: begin
                data_put_d = granted_s && bus.rx_data_put;
                data_d     = bus.rx_data;
                if (bus.rx_pkt_end) begin
                    state_d = ST_EVAL;
                end else begin
                    state_d = ST_DATA;
                end
            end

            ST_EVAL: begin
                state_d  = ST_SEND_HS;
                hs_req_d = 1'b1;
                hs_pid_d = PID_ACK;
                if (!bus.rx_pkt_valid || !pid_is_data_s
                    || (is_setup_q && (bus.rx_pid == PID_DATA1))) begin
                    // corrupt or illegal data stage: stay silent, host retries
                    rollback_d = granted_s;
                    hs_req_d   = 1'b0;
                    hs_pid_d   = 4'h0;
                    state_d    = ST_IDLE;
                end else if (!is_setup_q && bus.out_ep_stall[ep_q]) begin
                    rollback_d = granted_s;
                    hs_pid_d   = PID_STALL;
                end else if (!granted_s) begin
                    hs_pid_d   = PID_NAK;
                end else if (is_setup_q) begin
                    // SETUP always lands and resynchronises the toggle
                    acked_d          = 1'b1;
                    toggle_d[ep_q]   = 1'b1;
                end else if (bus.rx_pid[3] != toggle_q[ep_q]) begin
                    // host missed our last ACK: acknowledge again, drop the copy
                    rollback_d = 1'b1;
                end else begin
                    acked_d        = 1'b1;
                    toggle_d[ep_q] = ~toggle_q[ep_q];
                end
            end

            ST_SEND_HS: begin
                grant_d = {NUM_OUT_EP{1'b0}};
                setup_d = 1'b0;
                if (hs_req_q && bus.tx_hs_grant) begin
                    hs_req_d = 1'b0;
                    hs_pid_d = 4'h0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_SEND_HS;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                grant_d  = {NUM_OUT_EP{1'b0}};
                setup_d  = 1'b0;
                hs_req_d = 1'b0;
                hs_pid_d = 4'h0;
            end
        endcase
    end

    assign bus.out_ep_grant    = grant_q;
    assign bus.out_ep_setup    = setup_q;
    assign bus.out_ep_data_put = data_put_q;
    assign bus.out_ep_data     = data_q;
    assign bus.out_ep_acked    = acked_q;
    assign bus.out_ep_rollback = rollback_q;
    assign bus.tx_hs_req       = hs_req_q;
    assign bus.tx_hs_pid       = hs_pid_q;
endmodule

// File: doc/usb_fs_out_arb.md
Name: usb_fs_out_arb

Overview:
- Sequences the USB FS receive path for host-to-device transfers.
- Watches decoded token and data packets from the receiver (clk domain).
- Routes OUT/SETUP payload bytes to one of NUM_OUT_EP endpoint buffers, tracks per-endpoint DATA0/DATA1 toggles, and decides the ACK/NAK/STALL handshake.
- The handshake is requested from the shared transmit path over a req/grant interface.

Parameters:
NUM_OUT_EP, 2, number of OUT endpoints served (1..16); endpoint index = token endp
TIMEOUT, 255, clk cycles to wait for a data packet after a matching token before abandoning

Ports:
clk  input  1  endpoint-domain clock
reset  input  1  asynchronous, active-low reset
dev_addr  input  7  current device address
rx_pkt_start  input  1  pulse, receiver packet start
rx_pkt_end  input  1  pulse, receiver packet end
rx_pid  input  4  last packet PID
rx_addr  input  7  last token address
rx_endp  input  4  last token endpoint
rx_pkt_valid  input  1  last packet passed PID/CRC checks (level)
rx_data_put  input  1  pulse, rx_data valid
rx_data  input  8  received payload byte
out_ep_data_avail  input  NUM_OUT_EP  endpoint buffer can accept a full packet
out_ep_stall  input  NUM_OUT_EP  endpoint halted
out_ep_grant  output  NUM_OUT_EP  one-hot, endpoint owns current data packet
out_ep_setup  output  1  current transfer is SETUP (valid while grant high)
out_ep_data_put  output  1  byte strobe to granted endpoint
out_ep_data  output  8  byte to granted endpoint
out_ep_acked  output  1  pulse, commit packet in granted endpoint
out_ep_rollback  output  1  pulse, discard packet in granted endpoint
tx_hs_req  output  1  handshake request to tx path
tx_hs_pid  output  4  handshake PID
tx_hs_grant  input  1  tx path accepted handshake

Behaviour:
- Reset (async, low): all outputs 0, FSM IDLE, all toggles 0, timeout counter 0.
- PIDs: OUT 0001, SETUP 1101, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110.
- Packet fields (rx_pid, rx_addr, rx_endp, rx_pkt_valid) are sampled the cycle after rx_pkt_end (registered end strobe).
- FSM states: IDLE, WAIT_DATA, DATA, EVAL, SEND_HS.
- IDLE:
  - Accept a token when valid, pid is OUT or SETUP, rx_addr==dev_addr, and rx_endp<NUM_OUT_EP.
  - On accept: latch ep=rx_endp and is_setup, clear the timer, go WAIT_DATA.
  - Any other packet is ignored.
- WAIT_DATA:
  - Timer increments each cycle. At TIMEOUT go IDLE with no outputs.
  - On rx_pkt_start go DATA. If out_ep_data_avail[ep] is set, drive out_ep_grant[ep]=1 and out_ep_setup=is_setup from the next cycle.
  - A rx_pkt_end seen here (a token arrived instead of data) → IDLE.
- DATA:
  - While granted, out_ep_data_put = registered rx_data_put, 1-cycle latency, with out_ep_data aligned.
  - Not granted: bytes dropped.
  - On rx_pkt_end go EVAL.
- EVAL (uses fields sampled after the end strobe):
  - not valid, or pid not DATA0/DATA1, or is_setup with DATA1 → rollback pulse if granted; no handshake; IDLE.
  - !is_setup and out_ep_stall[ep] → rollback if granted; STALL.
  - not granted → NAK.
  - is_setup → acked pulse; toggle[ep]←1; ACK. SETUP ignores stall and toggle.
  - data PID toggle ≠ toggle[ep] (duplicate) → rollback pulse; ACK; toggle unchanged.
  - otherwise → acked pulse; toggle[ep] flips; ACK.
  - acked and rollback are never high together. Each is 1 cycle, issued while grant is still high.
- SEND_HS:
  - Drop grant and setup the cycle after EVAL.
  - Hold tx_hs_req=1 and tx_hs_pid stable until a cycle with tx_hs_grant=1.
  - Then deassert the next cycle and go IDLE.
- Tokens arriving in SEND_HS or DATA are not accepted as new transfers.
- Reset mid-transfer: immediate clear. The endpoint sees grant fall without acked. Endpoints treat that as rollback.
- Only one grant bit is ever high. Grant is never high outside DATA/EVAL.

Test Plan:
- dev_addr=5, OUT addr5 ep1, DATA0 with 8 bytes, avail[1]=1, toggle=0 → grant=2'b10, 8 data_put, acked pulse, tx_hs_pid=ACK, toggle[1]=1.
- Repeat the same DATA0 on ep1 → 8 bytes forwarded, rollback pulse, ACK, toggle[1] stays 1.
- OUT ep0, avail[0]=0 → no grant, no data_put, NAK. With avail=1 and stall[0]=1 → rollback, STALL.
- SETUP ep0 with stall[0]=1, DATA0 8 bytes → setup=1, acked, ACK, toggle[0]=1. SETUP followed by DATA1 → rollback, no tx_hs_req.
- OUT to addr 6 or endp≥NUM_OUT_EP, or a bad-CRC token → FSM stays IDLE, no outputs. Valid token with no data for 255 cycles → IDLE, no handshake.
- tx_hs_grant held low 20 cycles → tx_hs_req/pid held stable. Assert reset mid-DATA → grant, data_put and req all 0 immediately; toggles 0.
